// File: rtl/universal_shift_counter_if.sv
// Command/data bundle for universal_shift_counter.
// The master side issues commands and observes the register; the slave side is the block.
interface universal_shift_counter_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [CNT_W-1:0] cmd_cnt;
    logic [WIDTH-1:0] data_in;
    logic             ser_in;
    logic [WIDTH-1:0] data_out;
    logic             ser_out;
    logic             busy;
    logic             done;
    logic             tc;

    modport master (
        output cmd_valid, cmd_op, cmd_cnt, data_in, ser_in,
        input  cmd_ready, data_out, ser_out, busy, done, tc
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_cnt, data_in, ser_in,
        output cmd_ready, data_out, ser_out, busy, done, tc
    );
endinterface

// File: rtl/universal_shift_counter.sv
// WIDTH-bit register with load, clear, shift, rotate and up/down count.
// Each command runs cmd_cnt steps (one per clock); step 1 lands on the accept edge,
// the rest are sequenced by a two-state IDLE/RUN controller with a remaining-step counter.
module universal_shift_counter #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    universal_shift_counter_if.slave bus
);

    localparam logic [2:0] OP_LOAD  = 3'd0;
    localparam logic [2:0] OP_SHL   = 3'd1;
    localparam logic [2:0] OP_SHR   = 3'd2;
    localparam logic [2:0] OP_ROL   = 3'd3;
    localparam logic [2:0] OP_ROR   = 3'd4;
    localparam logic [2:0] OP_UP    = 3'd5;
    localparam logic [2:0] OP_DN    = 3'd6;
    localparam logic [2:0] OP_CLEAR = 3'd7;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] remain_reg, remain_next;
    logic [2:0]       op_reg, op_next;
    logic [WIDTH-1:0] data_reg, data_next;
    logic             ser_reg, ser_next;
    logic             done_reg, done_next;
    logic             tc_reg, tc_next;

    logic             accept;
    logic             step_en;
    logic [2:0]       step_op;

    assign accept        = bus.cmd_valid && (state_reg == IDLE);
    assign bus.cmd_ready = (state_reg == IDLE);
    assign bus.busy      = (state_reg == RUN);
    assign bus.data_out  = data_reg;
    assign bus.ser_out   = ser_reg;
    assign bus.done      = done_reg;
    assign bus.tc        = tc_reg;

    // Controller state, step counter and latched opcode
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            remain_reg <= '0;
            op_reg     <= OP_LOAD;
            done_reg   <= 1'b0;
        end else begin
            state_reg  <= state_next;
            remain_reg <= remain_next;
            op_reg     <= op_next;
            done_reg   <= done_next;
        end
    end

    // Next-state logic: decides whether this edge applies a step, with which op, and when done fires
    always_comb begin
        state_next  = state_reg;
        remain_next = remain_reg;
        op_next     = op_reg;
        done_next   = 1'b0;
        step_en     = 1'b0;
        step_op     = op_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    step_op = bus.cmd_op;
                    op_next = bus.cmd_op;
                    if (bus.cmd_op == OP_LOAD || bus.cmd_op == OP_CLEAR) begin
                        // Single-step ops ignore the step count entirely
                        step_en   = 1'b1;
                        done_next = 1'b1;
                    end else if (bus.cmd_cnt == '0) begin
                        // Zero steps: nothing changes, but the command still completes
                        done_next = 1'b1;
                    end else begin
                        step_en = 1'b1;
                        if (bus.cmd_cnt == CNT_W'(1)) begin
                            done_next = 1'b1;
                        end else begin
                            state_next  = RUN;
                            remain_next = bus.cmd_cnt - CNT_W'(1);
                        end
                    end
                end
            end
            RUN: begin
                step_en     = 1'b1;
                remain_next = remain_reg - CNT_W'(1);
                if (remain_reg == CNT_W'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Datapath: compute the register, serial-out and wrap flag for one step
    always_comb begin
        data_next = data_reg;
        ser_next  = ser_reg;
        tc_next   = 1'b0;
        if (step_en) begin
            case (step_op)
                OP_LOAD: data_next = bus.data_in;
                OP_SHL: begin
                    data_next = {data_reg[WIDTH-2:0], bus.ser_in};
                    ser_next  = data_reg[WIDTH-1];
                end
                OP_SHR: begin
                    data_next = {bus.ser_in, data_reg[WIDTH-1:1]};
                    ser_next  = data_reg[0];
                end
                OP_ROL: data_next = {data_reg[WIDTH-2:0], data_reg[WIDTH-1]};
                OP_ROR: data_next = {data_reg[0], data_reg[WIDTH-1:1]};
                OP_UP: begin
                    data_next = data_reg + WIDTH'(1);
                    tc_next   = &data_reg;
                end
                OP_DN: begin
                    data_next = data_reg - WIDTH'(1);
                    tc_next   = ~|data_reg;
                end
                default: data_next = '0;
            endcase
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_reg <= '0;
            ser_reg  <= 1'b0;
            tc_reg   <= 1'b0;
        end else begin
            data_reg <= data_next;
            ser_reg  <= ser_next;
            tc_reg   <= tc_next;
        end
    end

endmodule

// File: tb/tb_universal_shift_counter.sv
// Bench for universal_shift_counter: a 16-bit and a 4-bit instance checked every cycle
// against a step-by-step arithmetic model, plus directed sequences with literal values.
module tb_universal_shift_counter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad = 0;
    bit   cmp_on = 1'b0;

    always #5 clk = ~clk;

    universal_shift_counter_if #(.WIDTH(16), .CNT_W(5)) b16 ();
    universal_shift_counter_if #(.WIDTH(4),  .CNT_W(3)) b4 ();

    universal_shift_counter #(.WIDTH(16), .CNT_W(5)) u16 (
        .clk(clk), .rst_n(rst_n), .bus(b16.slave)
    );
    universal_shift_counter #(.WIDTH(4), .CNT_W(3)) u4 (
        .clk(clk), .rst_n(rst_n), .bus(b4.slave)
    );

    // ---------------- behavioural model ----------------
    int         wid [2] = '{16, 4};
    int         m_data [2];
    int         m_ser [2];
    int         m_done [2];
    int         m_tc [2];
    int         m_left [2];
    int         m_op [2];

    task automatic model_reset(int i);
        m_data[i] = 0; m_ser[i] = 0; m_done[i] = 0; m_tc[i] = 0; m_left[i] = 0; m_op[i] = 0;
    endtask

    task automatic apply_op(int i, int op, int si);
        int w, mask, d, msb;
        w = wid[i];
        mask = (1 << w) - 1;
        d = m_data[i];
        msb = (d >> (w - 1)) & 1;
        case (op)
            1: begin m_data[i] = ((d << 1) | si) & mask; m_ser[i] = msb; end
            2: begin m_data[i] = (d >> 1) | (si << (w - 1)); m_ser[i] = d & 1; end
            3: m_data[i] = ((d << 1) | msb) & mask;
            4: m_data[i] = (d >> 1) | ((d & 1) << (w - 1));
            5: begin m_data[i] = (d + 1) % (mask + 1); m_tc[i] = (m_data[i] == 0) ? 1 : 0; end
            6: begin m_data[i] = (d + mask) % (mask + 1); m_tc[i] = (d == 0) ? 1 : 0; end
            default: m_data[i] = d;
        endcase
    endtask

    task automatic model_step(int i, logic v, int op, int cnt, int din, int si);
        m_done[i] = 0;
        m_tc[i] = 0;
        if (m_left[i] > 0) begin
            apply_op(i, m_op[i], si);
            m_left[i] = m_left[i] - 1;
            if (m_left[i] == 0) m_done[i] = 1;
        end else if (v) begin
            if (op == 0) begin
                m_data[i] = din & ((1 << wid[i]) - 1);
                m_done[i] = 1;
            end else if (op == 7) begin
                m_data[i] = 0;
                m_done[i] = 1;
            end else if (cnt == 0) begin
                m_done[i] = 1;
            end else begin
                m_op[i] = op;
                apply_op(i, op, si);
                m_left[i] = cnt - 1;
                if (cnt == 1) m_done[i] = 1;
            end
        end
    endtask

    // Model advance for the 16-bit instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset(0);
        else model_step(0, b16.cmd_valid, int'(b16.cmd_op), int'(b16.cmd_cnt),
                        int'(b16.data_in), int'(b16.ser_in));
    end

    // Model advance for the 4-bit instance
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset(1);
        else model_step(1, b4.cmd_valid, int'(b4.cmd_op), int'(b4.cmd_cnt),
                        int'(b4.data_in), int'(b4.ser_in));
    end

    // ---------------- checking ----------------
    task automatic check(string name, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model
    always @(negedge clk) begin
        if (rst_n === 1'b1 && cmp_on) begin
            check("m16_data",  int'(b16.data_out),  m_data[0]);
            check("m16_ser",   int'(b16.ser_out),   m_ser[0]);
            check("m16_done",  int'(b16.done),      m_done[0]);
            check("m16_tc",    int'(b16.tc),        m_tc[0]);
            check("m16_busy",  int'(b16.busy),      (m_left[0] > 0) ? 1 : 0);
            check("m16_ready", int'(b16.cmd_ready), (m_left[0] == 0) ? 1 : 0);
            check("m4_data",   int'(b4.data_out),   m_data[1]);
            check("m4_ser",    int'(b4.ser_out),    m_ser[1]);
            check("m4_done",   int'(b4.done),       m_done[1]);
            check("m4_tc",     int'(b4.tc),         m_tc[1]);
            check("m4_busy",   int'(b4.busy),       (m_left[1] > 0) ? 1 : 0);
            check("m4_ready",  int'(b4.cmd_ready),  (m_left[1] == 0) ? 1 : 0);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send16(logic [2:0] op, logic [4:0] cnt, logic [15:0] d);
        check("ready_before_send16", int'(b16.cmd_ready), 1);
        $display("send16 op=%0d cnt=%0d data=%h", op, cnt, d);
        b16.cmd_op = op; b16.cmd_cnt = cnt; b16.data_in = d; b16.cmd_valid = 1'b1;
        tick();
        b16.cmd_valid = 1'b0;
    endtask

    task automatic send4(logic [2:0] op, logic [2:0] cnt, logic [3:0] d);
        check("ready_before_send4", int'(b4.cmd_ready), 1);
        $display("send4 op=%0d cnt=%0d data=%h", op, cnt, d);
        b4.cmd_op = op; b4.cmd_cnt = cnt; b4.data_in = d; b4.cmd_valid = 1'b1;
        tick();
        b4.cmd_valid = 1'b0;
    endtask

    logic [15:0] exp_rol [4] = '{16'h0003, 16'h0006, 16'h000C, 16'h0018};
    logic [15:0] exp_ror [5] = '{16'h8000, 16'h4000, 16'h2000, 16'h1000, 16'h0800};
    logic [3:0]  exp_c4  [7] = '{4'hD, 4'hE, 4'hF, 4'h0, 4'h1, 4'h2, 4'h3};

    initial begin
        int tc_pulses;
        b16.cmd_valid = 0; b16.cmd_op = 0; b16.cmd_cnt = 0; b16.data_in = 0; b16.ser_in = 0;
        b4.cmd_valid = 0;  b4.cmd_op = 0;  b4.cmd_cnt = 0;  b4.data_in = 0;  b4.ser_in = 0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
        cmp_on = 1'b1;

        // reset state
        check("rst_data", int'(b16.data_out), 0);
        check("rst_ready", int'(b16.cmd_ready), 1);
        check("rst_busy_done_tc", int'({b16.busy, b16.done, b16.tc, b16.ser_out}), 0);

        // LOAD then ROL N=4
        send16(3'd0, 5'd0, 16'h8001);
        check("load_data", int'(b16.data_out), 16'h8001);
        check("load_done", int'(b16.done), 1);
        send16(3'd3, 5'd4, 16'h0);
        for (int k = 0; k < 4; k++) begin
            check("rol_data", int'(b16.data_out), int'(exp_rol[k]));
            check("rol_ready", int'(b16.cmd_ready), (k == 3) ? 1 : 0);
            check("rol_done", int'(b16.done), (k == 3) ? 1 : 0);
            if (k < 3) tick();
        end

        // LOAD 0x0005 then SHR N=3 with ser_in 1,0,1
        send16(3'd0, 5'd0, 16'h0005);
        b16.ser_in = 1'b1;
        send16(3'd2, 5'd3, 16'h0);
        check("shr1_data", int'(b16.data_out), 16'h8002);
        check("shr1_ser", int'(b16.ser_out), 1);
        b16.ser_in = 1'b0;
        tick();
        check("shr2_data", int'(b16.data_out), 16'h4001);
        check("shr2_ser", int'(b16.ser_out), 0);
        b16.ser_in = 1'b1;
        tick();
        check("shr3_data", int'(b16.data_out), 16'hA000);
        check("shr3_ser", int'(b16.ser_out), 1);
        b16.ser_in = 1'b0;

        // count wrap up and down
        send16(3'd0, 5'd0, 16'hFFFE);
        send16(3'd5, 5'd3, 16'h0);
        check("up1", int'({b16.tc, b16.data_out}), 32'h0FFFF);
        tick();
        check("up2", int'({b16.tc, b16.data_out}), 32'h10000);
        tick();
        check("up3", int'({b16.tc, b16.data_out}), 32'h00001);
        send16(3'd6, 5'd2, 16'h0);
        check("dn1", int'({b16.tc, b16.data_out}), 32'h00000);
        tick();
        check("dn2", int'({b16.tc, b16.data_out}), 32'h1FFFF);

        // SHL N=0 leaves everything alone but still completes
        send16(3'd1, 5'd0, 16'h0);
        check("shl0_data", int'(b16.data_out), 16'hFFFF);
        check("shl0_ser", int'(b16.ser_out), 1);
        check("shl0_done", int'(b16.done), 1);
        check("shl0_ready", int'(b16.cmd_ready), 1);

        // ROR N=5 with a CLEAR presented while busy
        send16(3'd0, 5'd0, 16'h0001);
        send16(3'd4, 5'd5, 16'h0);
        check("ror_data0", int'(b16.data_out), int'(exp_ror[0]));
        b16.cmd_op = 3'd7; b16.cmd_cnt = 5'd0; b16.cmd_valid = 1'b1;
        for (int k = 1; k < 5; k++) begin
            tick();
            check("ror_data", int'(b16.data_out), int'(exp_ror[k]));
            check("ror_done", int'(b16.done), (k == 4) ? 1 : 0);
        end
        tick();
        b16.cmd_valid = 1'b0;
        check("clear_data", int'(b16.data_out), 0);
        check("clear_done", int'(b16.done), 1);

        // asynchronous reset in the middle of a long ROL
        send16(3'd0, 5'd0, 16'h1234);
        send16(3'd3, 5'd10, 16'h0);
        repeat (3) tick();
        check("pre_rst_busy", int'(b16.busy), 1);
        #3 rst_n = 1'b0;
        #1;
        check("arst_data", int'(b16.data_out), 0);
        check("arst_flags", int'({b16.busy, b16.done, b16.tc, b16.ser_out}), 0);
        #2 rst_n = 1'b1;
        #1;
        check("arst_ready", int'(b16.cmd_ready), 1);
        for (int k = 0; k < 12; k++) begin
            tick();
            check("arst_no_done", int'(b16.done), 0);
        end

        // 4-bit instance: CNT_UP N=7 from 0xC
        send4(3'd0, 3'd0, 4'hC);
        send4(3'd5, 3'd7, 4'h0);
        tc_pulses = 0;
        for (int k = 0; k < 7; k++) begin
            check("c4_data", int'(b4.data_out), int'(exp_c4[k]));
            check("c4_done", int'(b4.done), (k == 6) ? 1 : 0);
            tc_pulses += int'(b4.tc);
            if (k < 6) tick();
        end
        tick();
        tc_pulses += int'(b4.tc);
        check("c4_tc_pulses", tc_pulses, 1);
        check("c4_done_after", int'(b4.done), 0);

        // randomized traffic on both instances, checked by the per-cycle compare
        for (int c = 0; c < 1500; c++) begin
            b16.cmd_valid = ($urandom_range(0, 2) != 0);
            b16.cmd_op    = 3'($urandom_range(0, 7));
            b16.cmd_cnt   = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 3));
            b16.data_in   = 16'($urandom);
            b16.ser_in    = 1'($urandom);
            b4.cmd_valid  = ($urandom_range(0, 2) != 0);
            b4.cmd_op     = 3'($urandom_range(0, 7));
            b4.cmd_cnt    = 3'($urandom);
            b4.data_in    = 4'($urandom);
            b4.ser_in     = 1'($urandom);
            tick();
        end
        b16.cmd_valid = 1'b0;
        b4.cmd_valid = 1'b0;
        repeat (40) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/universal_shift_counter.md
Name: universal_shift_counter

Overview:
- Parametrised successor to the fixed 16-bit rotate register and the 4-bit ripple/synchronous counters.
- One WIDTH-bit register supports parallel load, clear, logical shift with serial in/out, rotate, and up/down count.
- Each command runs a programmable number of steps, one step per clock, under a valid/ready command handshake with a done pulse.
- Intended as the shared datapath register for the lab's serial I/O and timing blocks.

Parameters:
- WIDTH, 16, register width in bits (≥2).
- CNT_W, 5, width of the step-count field; max steps per command = 2^CNT_W − 1.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  block can accept a command this cycle.
- cmd_op  input  3  operation code, sampled on accept.
- cmd_cnt  input  CNT_W  number of steps, sampled on accept.
- data_in  input  WIDTH  parallel load value, sampled on accept.
- ser_in  input  1  serial input, sampled live on every shift step.
- data_out  output  WIDTH  register contents.
- ser_out  output  1  last bit shifted out by SHL/SHR.
- busy  output  1  multi-step command in progress.
- done  output  1  one-cycle pulse after a command's final update.
- tc  output  1  one-cycle pulse: the preceding step was a count wrap.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - data_out=0, ser_out=0, busy=0, done=0, tc=0.
  - FSM returns to IDLE; any in-flight command is discarded.
  - cmd_ready=1 after reset is released.
- cmd_op encoding:
  - 000 LOAD: data_in.
  - 001 SHL: {d[W-2:0], ser_in}; ser_out ← d[W-1].
  - 010 SHR: {ser_in, d[W-1:1]}; ser_out ← d[0].
  - 011 ROL: {d[W-2:0], d[W-1]}.
  - 100 ROR: {d[0], d[W-1:1]}.
  - 101 CNT_UP: d+1 mod 2^W.
  - 110 CNT_DN: d−1 mod 2^W.
  - 111 CLEAR: 0.
- FSM states:
  - IDLE: cmd_ready=1, busy=0.
  - RUN: cmd_ready=0, busy=1; holds a remaining-step counter.
- Accept occurs on an edge where cmd_valid=1 and cmd_ready=1.
- LOAD and CLEAR:
  - Single step applied on the accept edge; cmd_cnt is ignored.
  - done=1 in the following cycle; FSM stays in IDLE.
- Shift, rotate and count ops with cmd_cnt=N≥1:
  - Step 1 is applied on the accept edge; steps 2..N on the following N−1 edges.
  - Total latency is N cycles.
  - N=1: FSM stays in IDLE.
  - N≥2: FSM enters RUN with remaining=N−1, decrements each step, and returns to IDLE on the edge applying step N.
  - done is registered: high for exactly the one cycle after the edge applying step N.
  - cmd_ready rises in that same cycle, so back-to-back commands are allowed (done and a new accept may coincide).
- cmd_cnt=0 (non-LOAD/CLEAR): register and ser_out unchanged, done pulses next cycle, FSM stays in IDLE.
- cmd_valid while cmd_ready=0 is ignored; the command is not queued.
- cmd_op, cmd_cnt and data_in are don't-care after accept (latched internally).
- ser_in can change every cycle; each shift step uses its current value.
- ser_out:
  - Updates only on SHL/SHR steps.
  - Holds its value through other ops and idle cycles.
- tc:
  - Set for one cycle after a CNT_UP step from all-ones to 0, or a CNT_DN step from 0 to all-ones.
  - Otherwise 0.
  - Multiple wraps within one command give multiple pulses.
- There is no hold/enable input: IDLE with no accept holds all state.

Test Plan:
- Async reset mid-RUN (ROL, N=10, reset asserted at step 4, between edges) → data_out=0, busy=0, done=0, tc=0 immediately; cmd_ready=1 after release; no done pulse afterwards.
- LOAD 0x8001, then ROL N=4 → data_out 0x0003, 0x0006, 0x000C, 0x0018 on successive edges; cmd_ready low for cycles 2–4; done high only the cycle after 0x0018.
- LOAD 0x0005, then SHR N=3 with ser_in=1,0,1 → data_out 0x8002, 0x4001, 0xA000; ser_out 1, 0, 1; final ser_out=1.
- LOAD 0xFFFE, CNT_UP N=3 → 0xFFFF, 0x0000, 0x0001, with tc high only in the cycle showing 0x0000; then CNT_DN N=2 → 0x0000, 0xFFFF, with tc pulse at 0xFFFF.
- SHL with N=0 → data_out and ser_out unchanged, done pulse next cycle, cmd_ready stays 1. Then ROR N=5 with a CLEAR presented on cycle 2 → CLEAR ignored, ROR completes; CLEAR re-presented in the done cycle is accepted and data_out=0.
- WIDTH=4, CNT_W=3 instance: CNT_UP N=7 from 0xC → 0xD, 0xE, 0xF, 0x0, 0x1, 0x2, 0x3; exactly one tc pulse; done after the 7th step.
